// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, requester IDs and
// byte-lane strobe encodings.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Requester IDs double as bit positions in the one-hot grant vector.
    localparam int unsigned REQ_LD  = 0;
    localparam int unsigned REQ_CPU = 1;
    localparam int unsigned REQ_AUX = 2;

    // Only the low byte lane is ever strobed.
    localparam logic [1:0] STB_LO  = 2'b10;
    localparam logic [1:0] STB_OFF = 2'b11;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selector for the SRAM arbiter.
// LD always wins; LD_LOCK restricts eligibility to LD alone.
// With SRAM_ARB_RR_EN defined, CPU/AUX ties go to the requester that did not
// win last time; otherwise CPU beats AUX.
module sram_arb_pick
    import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
    input  logic       last_aux,
`endif
    input  logic       ld_req,
    input  logic       cpu_req,
    input  logic       aux_req,
    input  logic       ld_lock,
    output logic [2:0] grant
);

    // Priority resolution into a one-hot grant
    always_comb begin
        grant = '0;
        if (ld_req) begin
            grant[REQ_LD] = 1'b1;
        end else if (!ld_lock) begin
`ifdef SRAM_ARB_RR_EN
            if (cpu_req && aux_req) begin
                if (last_aux) grant[REQ_CPU] = 1'b1;
                else          grant[REQ_AUX] = 1'b1;
            end else if (cpu_req) begin
                grant[REQ_CPU] = 1'b1;
            end else if (aux_req) begin
                grant[REQ_AUX] = 1'b1;
            end
`else
            if (cpu_req)      grant[REQ_CPU] = 1'b1;
            else if (aux_req) grant[REQ_AUX] = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Timed access sequencer sharing one async 16-bit SRAM between the loader,
// the Z80 CPU and an auxiliary requester. Low byte lane only.
// Optional macro SRAM_ARB_RR_EN: round-robin between CPU and AUX.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 21,
    parameter int unsigned ACCESS_CYCLES = 2
)(
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              LD_LOCK,
    input  logic              LD_REQ,
    input  logic              LD_WE,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [7:0]        LD_DI,
    output logic              LD_ACK,
    output logic [7:0]        LD_DO,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [7:0]        CPU_DI,
    output logic              CPU_ACK,
    output logic [7:0]        CPU_DO,
    input  logic              AUX_REQ,
    input  logic              AUX_WE,
    input  logic [ADDR_W-1:0] AUX_ADDR,
    input  logic [7:0]        AUX_DI,
    output logic              AUX_ACK,
    output logic [7:0]        AUX_DO,
    output logic              BUSY,
    output logic [ADDR_W-1:0] MA,
    input  logic [15:0]       MD_I,
    output logic [15:0]       MD_O,
    output logic              MD_OE,
    output logic [1:0]        MRD_N,
    output logic [1:0]        MWR_N
);

    state_t            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        di_q, di_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        ld_do_q, ld_do_d;
    logic [7:0]        cpu_do_q, cpu_do_d;
    logic [7:0]        aux_do_q, aux_do_d;
    logic [2:0]        pick_gnt;
    logic              md_hi_unused;

    assign md_hi_unused = ^MD_I[15:8];

`ifdef SRAM_ARB_RR_EN
    logic last_aux_q, last_aux_d;
`endif

    sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
        .last_aux (last_aux_q),
`endif
        .ld_req   (LD_REQ),
        .cpu_req  (CPU_REQ),
        .aux_req  (AUX_REQ),
        .ld_lock  (LD_LOCK),
        .grant    (pick_gnt)
    );

    // Next-state logic: grant latch, access timing and read-data capture
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        di_d     = di_q;
        cnt_d    = cnt_q;
        ld_do_d  = ld_do_q;
        cpu_do_d = cpu_do_q;
        aux_do_d = aux_do_q;
`ifdef SRAM_ARB_RR_EN
        last_aux_d = last_aux_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    gnt_d   = pick_gnt;
                    state_d = SETUP;
                    if (pick_gnt[REQ_LD]) begin
                        we_d = LD_WE;  addr_d = LD_ADDR;  di_d = LD_DI;
                    end else if (pick_gnt[REQ_CPU]) begin
                        we_d = CPU_WE; addr_d = CPU_ADDR; di_d = CPU_DI;
                    end else begin
                        we_d = AUX_WE; addr_d = AUX_ADDR; di_d = AUX_DI;
                    end
`ifdef SRAM_ARB_RR_EN
                    if (pick_gnt[REQ_CPU]) last_aux_d = 1'b0;
                    if (pick_gnt[REQ_AUX]) last_aux_d = 1'b1;
`endif
                end
            end
            SETUP: begin
                cnt_d   = 3'(ACCESS_CYCLES);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                    // Last strobe cycle: data is settled, latch it for the owner
                    if (!we_q) begin
                        if (gnt_q[REQ_LD])  ld_do_d  = MD_I[7:0];
                        if (gnt_q[REQ_CPU]) cpu_do_d = MD_I[7:0];
                        if (gnt_q[REQ_AUX]) aux_do_d = MD_I[7:0];
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            di_q     <= '0;
            cnt_q    <= '0;
            ld_do_q  <= 8'hFF;
            cpu_do_q <= 8'hFF;
            aux_do_q <= 8'hFF;
`ifdef SRAM_ARB_RR_EN
            last_aux_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            di_q     <= di_d;
            cnt_q    <= cnt_d;
            ld_do_q  <= ld_do_d;
            cpu_do_q <= cpu_do_d;
            aux_do_q <= aux_do_d;
`ifdef SRAM_ARB_RR_EN
            last_aux_q <= last_aux_d;
`endif
        end
    end

    // Pin and handshake decode from registered state
    always_comb begin
        MA      = addr_q;
        MD_O    = {8'h00, di_q};
        MD_OE   = we_q && (state_q != IDLE);
        MRD_N   = (!we_q && (state_q == SETUP || state_q == ACCESS)) ? STB_LO : STB_OFF;
        MWR_N   = (we_q && state_q == ACCESS) ? STB_LO : STB_OFF;
        BUSY    = (state_q != IDLE);
        LD_ACK  = (state_q == DONE) && gnt_q[REQ_LD];
        CPU_ACK = (state_q == DONE) && gnt_q[REQ_CPU];
        AUX_ACK = (state_q == DONE) && gnt_q[REQ_AUX];
        LD_DO   = ld_do_q;
        CPU_DO  = cpu_do_q;
        AUX_DO  = aux_do_q;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single transactions plus
// hand sequences for reset, contention, lock, REQ drop and continuous requests.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        ld_lock;
    logic [2:0]  req, we;
    logic [20:0] addr [3];
    logic [7:0]  di [3];
    logic [2:0]  ack;
    logic [7:0]  dout [3];
    logic        busy, md_oe;
    logic [20:0] ma;
    logic [15:0] md_i, md_o;
    logic [1:0]  mrd_n, mwr_n;

    logic [7:0]  mem [256];
    logic [7:0]  exp_do [3];
    int unsigned n_total = 0, n_pass = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic        we;
        logic [20:0] addr;
        logic [7:0]  di;
        logic [7:0]  exp_do;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(21), .ACCESS_CYCLES(2)) dut (
        .CLK(clk), .N_RESET(n_reset), .LD_LOCK(ld_lock),
        .LD_REQ(req[0]), .LD_WE(we[0]), .LD_ADDR(addr[0]), .LD_DI(di[0]),
        .LD_ACK(ack[0]), .LD_DO(dout[0]),
        .CPU_REQ(req[1]), .CPU_WE(we[1]), .CPU_ADDR(addr[1]), .CPU_DI(di[1]),
        .CPU_ACK(ack[1]), .CPU_DO(dout[1]),
        .AUX_REQ(req[2]), .AUX_WE(we[2]), .AUX_ADDR(addr[2]), .AUX_DI(di[2]),
        .AUX_ACK(ack[2]), .AUX_DO(dout[2]),
        .BUSY(busy), .MA(ma), .MD_I(md_i), .MD_O(md_o), .MD_OE(md_oe),
        .MRD_N(mrd_n), .MWR_N(mwr_n)
    );

    // Async SRAM model, indexed by the low address byte
    always_comb md_i = {8'hEE, mem[ma[7:0]]};
    always @(posedge clk) if (mwr_n == 2'b10) mem[ma[7:0]] <= md_o[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_dos(input string tag);
        for (int i = 0; i < 3; i++) check($sformatf("%s DO[%0d]", tag, i), {24'h0, dout[i]}, {24'h0, exp_do[i]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_cyc [3];
        int cpu_n, aux_n, last_id, alt_ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h55;
        mem[8'h23] = 8'h3C;
        exp_do = '{8'hFF, 8'hFF, 8'hFF};
        vecs[0] = '{2'd1, 1'b1, 21'h04000,  8'hA5, 8'h00};
        vecs[1] = '{2'd1, 1'b0, 21'h0C123,  8'h00, 8'h3C};
        vecs[2] = '{2'd0, 1'b1, 21'h00010,  8'h5A, 8'h00};
        vecs[3] = '{2'd2, 1'b0, 21'h00010,  8'h00, 8'h5A};
        vecs[4] = '{2'd0, 1'b0, 21'h0C123,  8'h00, 8'h3C};
        vecs[5] = '{2'd2, 1'b1, 21'h1FFFFF, 8'h81, 8'h00};
        vecs[6] = '{2'd1, 1'b0, 21'h1FFFFF, 8'h00, 8'h81};
        vecs[7] = '{2'd2, 1'b0, 21'h00000,  8'h00, 8'hA5};

        n_reset = 1'b0; ld_lock = 1'b0; req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; di[i] = '0; end
        @(negedge clk);
        repeat (3) step();
        check("rst MWR_N", {30'h0, mwr_n}, 32'h3);
        check("rst MRD_N", {30'h0, mrd_n}, 32'h3);
        check("rst MD_OE", {31'h0, md_oe}, 32'h0);
        check("rst BUSY",  {31'h0, busy},  32'h0);
        check("rst MA",    {11'h0, ma},    32'h0);
        check("rst MD_O",  {16'h0, md_o},  32'h0);
        check("rst ACK",   {29'h0, ack},   32'h0);
        check_dos("rst");
        n_reset = 1'b1;
        step();

        // Reset during a write strobe
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 21'h00055; di[1] = 8'h77;
        step(); step();
        check("midrst pre MWR_N", {30'h0, mwr_n}, 32'h2);
        n_reset = 1'b0; req[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("midrst MWR_N", {30'h0, mwr_n}, 32'h3);
            check("midrst MD_OE", {31'h0, md_oe}, 32'h0);
            check("midrst ACK",   {29'h0, ack},   32'h0);
        end
        n_reset = 1'b1;
        step();
        check("midrst ACK after", {29'h0, ack}, 32'h0);
        check_dos("midrst");

        // Single transactions from the vector table
        for (int v = 0; v < 8; v++) begin
            int id;
            id = int'(vecs[v].id);
            req[id] = 1'b1; we[id] = vecs[v].we; addr[id] = vecs[v].addr; di[id] = vecs[v].di;
            step();
            check($sformatf("v%0d SETUP MA", v), {11'h0, ma}, {11'h0, vecs[v].addr});
            check($sformatf("v%0d SETUP MD_OE", v), {31'h0, md_oe}, {31'h0, vecs[v].we});
            check($sformatf("v%0d SETUP MRD_N", v), {30'h0, mrd_n}, vecs[v].we ? 32'h3 : 32'h2);
            check($sformatf("v%0d SETUP MWR_N", v), {30'h0, mwr_n}, 32'h3);
            check($sformatf("v%0d SETUP BUSY", v), {31'h0, busy}, 32'h1);
            for (int k = 2; k <= 3; k++) begin
                step();
                check($sformatf("v%0d ACC%0d MWR_N", v, k), {30'h0, mwr_n}, vecs[v].we ? 32'h2 : 32'h3);
                check($sformatf("v%0d ACC%0d MRD_N", v, k), {30'h0, mrd_n}, vecs[v].we ? 32'h3 : 32'h2);
                check($sformatf("v%0d ACC%0d ACK", v, k), {29'h0, ack}, 32'h0);
                if (vecs[v].we) check($sformatf("v%0d ACC%0d MD_O", v, k), {16'h0, md_o}, {24'h0, vecs[v].di});
            end
            step();
            if (!vecs[v].we) exp_do[id] = vecs[v].exp_do;
            check($sformatf("v%0d DONE ACK", v), {29'h0, ack}, 32'h1 << id);
            check($sformatf("v%0d DONE MWR_N", v), {30'h0, mwr_n}, 32'h3);
            check($sformatf("v%0d DONE MRD_N", v), {30'h0, mrd_n}, 32'h3);
            check($sformatf("v%0d DONE MD_OE", v), {31'h0, md_oe}, {31'h0, vecs[v].we});
            check($sformatf("v%0d DONE MA", v), {11'h0, ma}, {11'h0, vecs[v].addr});
            check_dos($sformatf("v%0d DONE", v));
            req[id] = 1'b0;
            step();
            check($sformatf("v%0d after ACK", v), {29'h0, ack}, 32'h0);
            check_dos($sformatf("v%0d held", v));
        end

        // Three-way contention
        we = '0;
        addr[0] = 21'h00010; addr[1] = 21'h04000; addr[2] = 21'h1FFFF;
        req = 3'b111;
        ack_cyc = '{0, 0, 0};
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int i = 0; i < 3; i++) if (ack[i]) begin
                if (ack_cyc[i] == 0) ack_cyc[i] = c;
                req[i] = 1'b0;
            end
        end
        check("cont LD cycle", ack_cyc[0], 4);
`ifdef SRAM_ARB_RR_EN
        check("cont CPU/AUX cycles", ack_cyc[1] + ack_cyc[2], 23);
        check("cont CPU/AUX spread", (ack_cyc[1] > ack_cyc[2]) ? ack_cyc[1] - ack_cyc[2] : ack_cyc[2] - ack_cyc[1], 5);
`else
        check("cont CPU cycle", ack_cyc[1], 9);
        check("cont AUX cycle", ack_cyc[2], 14);
`endif
        exp_do = '{8'h5A, 8'hA5, 8'h81};
        check_dos("cont");

        // REQ dropped after grant: access still completes
        addr[1] = 21'h0C123; req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        step(); step();
        check("drop pre ACK", {29'h0, ack}, 32'h0);
        step();
        check("drop ACK", {29'h0, ack}, 32'h2);
        check("drop CPU_DO", {24'h0, dout[1]}, 32'h3C);

        // Lock blocks CPU until released
        step();
        ld_lock = 1'b1; addr[1] = 21'h00010; req[1] = 1'b1;
        cpu_n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ack[1] || busy) cpu_n++;
        end
        check("lock no CPU activity", cpu_n, 0);
        ld_lock = 1'b0;
        ack_cyc[1] = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (ack[1] && ack_cyc[1] == 0) begin ack_cyc[1] = c; req[1] = 1'b0; end
        end
        check("unlock CPU ACK cycle", ack_cyc[1], 4);
        check("unlock CPU_DO", {24'h0, dout[1]}, 32'h5A);

        // Continuous CPU + AUX requests
        req[1] = 1'b1; req[2] = 1'b1;
        cpu_n = 0; aux_n = 0; last_id = -1; alt_ok = 1;
        for (int c = 1; c <= 40; c++) begin
            step();
            for (int i = 1; i < 3; i++) if (ack[i]) begin
                if (i == 1) cpu_n++; else aux_n++;
                if (i == last_id) alt_ok = 0;
                last_id = i;
            end
        end
        req = '0;
`ifdef SRAM_ARB_RR_EN
        check("rr CPU count", cpu_n, 4);
        check("rr AUX count", aux_n, 4);
        check("rr alternation", alt_ok, 1);
`else
        check("fixed CPU count", cpu_n, 8);
        check("fixed AUX count", aux_n, 0);
`endif
        step(); step();
        check("final BUSY", {31'h0, busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single external 16-bit async SRAM (MA/MD/MRD_N/MWR_N) between three requesters:
  - MCU loader (rom/file loader)
  - Z80 CPU
  - AUX (future DMA/tape/blitter)
- Replaces the direct combinational MA/MD/MWR_N muxing in the top level with a registered, timed access FSM.
- Provides a read-data latch per requester. Sits between the top level and the SRAM pins, in the CLK (56 MHz) domain.

Parameters:
- ADDR_W, 21, SRAM address width.
- ACCESS_CYCLES, 2, clocks MRD_N/MWR_N held active (range 1..7).

Ports:
- CLK  in  1  system clock, 56 MHz.
- N_RESET  in  1  synchronous, active-low reset.
- LD_LOCK  in  1  loader session active; blocks CPU/AUX grants.
- LD_REQ  in  1  loader request, level.
- LD_WE  in  1  1=write, 0=read.
- LD_ADDR  in  ADDR_W  loader address.
- LD_DI  in  8  loader write data.
- LD_ACK  out  1  one-cycle completion pulse.
- LD_DO  out  8  loader read data.
- CPU_REQ, CPU_WE, CPU_ADDR, CPU_DI, CPU_ACK, CPU_DO: same as LD_*.
- AUX_REQ, AUX_WE, AUX_ADDR, AUX_DI, AUX_ACK, AUX_DO: same as LD_*.
- BUSY  out  1  FSM not in IDLE.
- MA  out  ADDR_W  SRAM address.
- MD_I  in  16  SRAM data in.
- MD_O  out  16  SRAM data out.
- MD_OE  out  1  top level drives MD when 1.
- MRD_N  out  2  byte-lane read strobes.
- MWR_N  out  2  byte-lane write strobes.

Behaviour:
- Clock/reset: one clock (CLK). Synchronous active-low reset N_RESET.
- Reset values:
  - FSM=IDLE, MA=0, MD_O=0, MD_OE=0, MRD_N=2'b11, MWR_N=2'b11.
  - All ACK=0, all DO=8'hFF, BUSY=0.
- Reset mid-access: strobes deassert on the reset edge. No ACK is issued.
- Lane rule: only the low byte lane is used. Active strobe value is 2'b10. MD_O={8'h00, DI}.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Sample REQs and pick the winner by priority: LD > CPU > AUX.
  - When LD_LOCK=1, only LD is eligible.
  - Latch grant, WE, ADDR and DI into registers.
  - If no REQ, stay in IDLE.
- SETUP (1 cycle):
  - MA=latched address. Strobes inactive.
  - Write: MD_OE=1.
  - Read: MRD_N=2'b10.
- ACCESS (ACCESS_CYCLES cycles, down-counter):
  - Write: MWR_N=2'b10.
  - Read: MRD_N=2'b10. MD_I[7:0] is captured on the last ACCESS cycle.
- DONE (1 cycle):
  - MWR_N=2'b11. MD_OE stays 1 for write data hold. MA held. MRD_N=2'b11.
  - Granted ACK=1. Granted DO updated (read) or unchanged (write).
- Latency: REQ sampled in IDLE at cycle t; ACK is high in cycle t+ACCESS_CYCLES+2. With the default (2), ACK at t+4.
- Handshake:
  - Requester holds REQ, WE, ADDR and DI stable until ACK.
  - Requester drops REQ in the cycle after ACK. A REQ still high in IDLE starts a new access, so continuous REQ gives back-to-back accesses every ACCESS_CYCLES+3 clocks.
  - DO holds its value until that requester's next read completes.
- REQ drop mid-access: the access completes and ACK still pulses. No abort.
- Simultaneous REQs: resolved only in IDLE. Losers wait. No preemption of an access in progress, including by LD.
- LD_LOCK rising mid CPU/AUX access: that access completes; the lock takes effect at the next IDLE.
- Address: MA = latched address, zero-extended/truncated to ADDR_W, with no remapping. Address decode stays in the top level.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: CPU and AUX arbitrate round-robin.
  - A 1-bit last-winner flag, reset value CPU, favours the other requester on a tie.
  - LD keeps absolute priority.
- Undefined: fixed priority LD > CPU > AUX. The flag is not instantiated.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state encoding constants (IDLE, SETUP, ACCESS, DONE)
  - requester IDs (REQ_LD=0, REQ_CPU=1, REQ_AUX=2)
  - lane strobe constants (STB_LO=2'b10, STB_OFF=2'b11)
- One sub-module, sram_arb_pick: combinational priority/round-robin grant selector (REQs, LD_LOCK, last-winner flag -> one-hot grant).
- FSM, timing counter and DO latches stay in sram_arbiter.

Test Plan:
- Reset: N_RESET=0 for 3 cycles mid-write -> next cycle MWR_N=2'b11, MD_OE=0, no ACK, all DO=8'hFF.
- CPU write: CPU_REQ=1, WE=1, ADDR=21'h04000, DI=8'hA5 at t -> SETUP at t+1 (MA=04000, MD_OE=1), MWR_N=2'b10 at t+2..t+3, CPU_ACK at t+4, MD_O[7:0]=A5 held through t+4.
- CPU read: SRAM model returns 8'h3C at 21'h0C123 -> CPU_ACK at t+4 with CPU_DO=3C, held after REQ drops.
- Contention: LD, CPU and AUX REQ in the same cycle -> order of ACK: LD, CPU, AUX, spaced 5 clocks apart.
- Lock: LD_LOCK=1, CPU_REQ=1, no LD_REQ -> no CPU_ACK for 20 cycles. LD_LOCK=0 -> CPU_ACK 4 cycles after the next IDLE.
- SRAM_ARB_RR_EN defined: CPU and AUX held high continuously -> ACKs alternate CPU, AUX, CPU, AUX. Undefined -> only CPU acked.
